// File: rtl/tx_packet_framer.sv
// tx_packet_framer: store-and-forward packet framer between a host write port
// and a link transmit port.
// Ports:
//   clk_net, rst_n                        - network clock, async active-low reset
//   wr_valid/wr_sop/wr_eop/wr_length/wr_data, wr_ready - host word input
//   valid_out/sop_out/eop_out/length_out/data_out, ready_in - link word output
//   drop_count                            - saturating count of dropped packets
// A packet becomes eligible for transmit only once its eop word is in the
// buffer. Aborted, stray and oversize packets are discarded and counted.
module tx_packet_framer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IPG   = 1
) (
  input  logic        clk_net,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic        wr_sop,
  input  logic        wr_eop,
  input  logic [2:0]  wr_length,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  output logic        valid_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic [2:0]  length_out,
  output logic [63:0] data_out,
  input  logic        ready_in,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned GW = 4;
  localparam logic [GW-1:0] GAP_LAST = GW'((IPG > 0) ? (IPG - 1) : 0);

  // 72-bit buffer entry
  typedef struct packed {
    logic [2:0]    pad;
    logic          sop;
    logic          eop;
    logic [LW-1:0] len;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  entry_t          mem_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   start_ptr_q, start_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            in_pkt_q, in_pkt_d;
  logic            discard_q, discard_d;
  logic            stray_q, stray_d;
  logic            commit_q, commit_d;
  logic [CW-1:0]   drop_count_q, drop_count_d;
  logic            wr_ready_q, wr_ready_d;
  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   data_q, data_d;

  logic            wr_acc;
  logic [PW-1:0]   wr_fill;
  entry_t          wr_entry;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  entry_t          mem_wdata;
  logic            drop_inc;
  logic            load;
  logic            pkt_dec;
  logic            eligible;
  logic            eligible_next;
  entry_t          rd_entry;
  logic            unused_pad;

  assign rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
  assign unused_pad = ^rd_entry.pad;

  // Host write side: packet assembly, commit, abort, oversize and stray handling
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    in_pkt_d    = in_pkt_q;
    discard_d   = discard_q;
    stray_d     = stray_q;
    commit_d    = 1'b0;
    drop_inc    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q[AW-1:0];
    mem_wdata   = '0;
    wr_acc      = wr_valid && wr_ready_q;
    wr_fill     = wr_ptr_q - rd_ptr_q;
    wr_entry    = '{pad: 3'b000, sop: wr_sop, eop: wr_eop,
                    len: (wr_eop ? wr_length : LW'(0)), data: wr_data};

    if (wr_acc) begin
      if (wr_sop) begin
        // A sop mid-packet aborts the old packet; the new one reuses its start slot.
        if (in_pkt_q) drop_inc = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = start_ptr_q[AW-1:0];
        mem_wdata = wr_entry;
        stray_d   = 1'b0;
        discard_d = 1'b0;
        wr_ptr_d  = start_ptr_q + PW'(1);
        if (wr_eop) begin
          start_ptr_d = start_ptr_q + PW'(1);
          in_pkt_d    = 1'b0;
          commit_d    = 1'b1;
        end else begin
          in_pkt_d    = 1'b1;
        end
      end else if (discard_q) begin
        discard_d = !wr_eop;
      end else if (in_pkt_q) begin
        if (wr_fill == PW'(DEPTH)) begin
          // Buffer already holds only this packet: it can never fit.
          drop_inc  = 1'b1;
          wr_ptr_d  = start_ptr_q;
          in_pkt_d  = 1'b0;
          discard_d = !wr_eop;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q[AW-1:0];
          mem_wdata = wr_entry;
          if (wr_eop) begin
            wr_ptr_d    = wr_ptr_q + PW'(1);
            start_ptr_d = wr_ptr_q + PW'(1);
            in_pkt_d    = 1'b0;
            commit_d    = 1'b1;
          end else if ((wr_fill == PW'(DEPTH - 1)) && (pkt_count_q == '0)) begin
            // Packet fills the buffer with nothing else queued: oversize.
            drop_inc  = 1'b1;
            wr_ptr_d  = start_ptr_q;
            in_pkt_d  = 1'b0;
            discard_d = 1'b1;
          end else begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
          end
        end
      end else begin
        // Stray word outside a packet: count once per run, run ends at eop.
        if (!stray_q) drop_inc = 1'b1;
        stray_d = !wr_eop;
      end
    end
  end

  // Link transmit FSM and output word register
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    len_d    = len_q;
    data_d   = data_q;
    load     = 1'b0;
    pkt_dec  = 1'b0;
    // A packet committed on the previous edge waits one more cycle.
    eligible      = pkt_count_q > PW'(commit_q);
    eligible_next = pkt_count_q > (PW'(commit_q) + PW'(1));

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_in) begin
          if (!eop_q) begin
            load = 1'b1;
          end else begin
            pkt_dec = 1'b1;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            len_d   = '0;
            data_d  = '0;
            if (IPG == 0) begin
              if (eligible_next) load = 1'b1;
              else               state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LAST;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (eligible) begin
            load    = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      valid_d  = 1'b1;
      sop_d    = rd_entry.sop;
      eop_d    = rd_entry.eop;
      len_d    = rd_entry.len;
      data_d   = rd_entry.data;
    end
  end

  // Shared counters and write-ready, computed from next-cycle state
  always_comb begin
    pkt_count_d  = pkt_count_q + PW'(commit_d) - PW'(pkt_dec);
    drop_count_d = (drop_inc && (drop_count_q != '1)) ? (drop_count_q + CW'(1)) : drop_count_q;
    wr_ready_d   = !(((wr_ptr_d - rd_ptr_d) == PW'(DEPTH)) && (pkt_count_d != '0));
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      in_pkt_q     <= 1'b0;
      discard_q    <= 1'b0;
      stray_q      <= 1'b0;
      commit_q     <= 1'b0;
      drop_count_q <= '0;
      wr_ready_q   <= 1'b0;
      state_q      <= IDLE;
      gap_q        <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      len_q        <= '0;
      data_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      in_pkt_q     <= in_pkt_d;
      discard_q    <= discard_d;
      stray_q      <= stray_d;
      commit_q     <= commit_d;
      drop_count_q <= drop_count_d;
      wr_ready_q   <= wr_ready_d;
      state_q      <= state_d;
      gap_q        <= gap_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      len_q        <= len_d;
      data_q       <= data_d;
    end
  end

  // Packet buffer storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk_net) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign wr_ready   = wr_ready_q;
  assign valid_out  = valid_q;
  assign sop_out    = sop_q;
  assign eop_out    = eop_q;
  assign length_out = len_q;
  assign data_out   = data_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb_tx_packet_framer: directed checks of tx_packet_framer (DEPTH=16, IPG=1).
module tb_tx_packet_framer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IPG   = 1;

  logic        clk_net = 1'b0;
  logic        rst_n   = 1'b1;
  logic        wr_valid, wr_sop, wr_eop;
  logic [2:0]  wr_length;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        valid_out, sop_out, eop_out;
  logic [2:0]  length_out;
  logic [63:0] data_out;
  logic        ready_in;
  logic [15:0] drop_count;
  logic [71:0] out_w;

  int checks = 0;
  int errors = 0;

  always #5 clk_net = ~clk_net;

  tx_packet_framer #(.DEPTH(DEPTH), .IPG(IPG)) dut (
    .clk_net    (clk_net),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_length  (wr_length),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .valid_out  (valid_out),
    .sop_out    (sop_out),
    .eop_out    (eop_out),
    .length_out (length_out),
    .data_out   (data_out),
    .ready_in   (ready_in),
    .drop_count (drop_count)
  );

  assign out_w = {2'b00, valid_out, sop_out, eop_out, length_out, data_out};

  task automatic cyc();
    @(posedge clk_net);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] ow(input logic v, input logic s, input logic e,
                                     input logic [2:0] l, input logic [63:0] d);
    return {2'b00, v, s, e, l, d};
  endfunction

  task automatic wr(input logic s, input logic e, input logic [2:0] l, input logic [63:0] d);
    wr_valid  = 1'b1;
    wr_sop    = s;
    wr_eop    = e;
    wr_length = l;
    wr_data   = d;
    cyc();
    wr_valid  = 1'b0;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    wr_length = 3'd0;
    wr_data   = 64'd0;
  endtask

  initial begin
    logic nr;
    logic sv;
    nr = 1'b0;
    sv = 1'b0;
    ready_in  = 1'b1;
    wr_valid  = 1'b0;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    wr_length = 3'd0;
    wr_data   = 64'd0;

    // Reset state and wr_ready release
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", out_w, 72'd0);
    chk("reset_wr_ready", 72'(wr_ready), 72'(0));
    chk("reset_drop", 72'(drop_count), 72'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("wr_ready_before_edge", 72'(wr_ready), 72'(0));
    cyc();
    chk("wr_ready_after_edge", 72'(wr_ready), 72'(1));

    // 3-word packet, link always ready
    wr(1'b1, 1'b0, 3'd0, 64'h1111_1111_1111_1111);
    wr(1'b0, 1'b0, 3'd0, 64'h2222_2222_2222_2222);
    wr(1'b0, 1'b1, 3'd5, 64'h3333_3333_3333_3333);
    chk("p3_idle_e0", 72'(valid_out), 72'(0));
    cyc();
    chk("p3_idle_e1", 72'(valid_out), 72'(0));
    cyc();
    chk("p3_w1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'h1111_1111_1111_1111));
    cyc();
    chk("p3_w2", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'h2222_2222_2222_2222));
    cyc();
    chk("p3_w3", out_w, ow(1'b1, 1'b0, 1'b1, 3'd5, 64'h3333_3333_3333_3333));
    cyc();
    chk("p3_gap", 72'(valid_out), 72'(0));
    repeat (3) cyc();

    // 4-word packet with ready_in 1,0,0,1
    wr(1'b1, 1'b0, 3'd0, 64'hA1A1_0000_0000_0001);
    wr(1'b0, 1'b0, 3'd0, 64'hA2A2_0000_0000_0002);
    wr(1'b0, 1'b0, 3'd0, 64'hA3A3_0000_0000_0003);
    wr(1'b0, 1'b1, 3'd0, 64'hA4A4_0000_0000_0004);
    cyc();
    cyc();
    chk("stall_w1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'hA1A1_0000_0000_0001));
    cyc();
    chk("stall_w2", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'hA2A2_0000_0000_0002));
    ready_in = 1'b0;
    cyc();
    chk("stall_w2_hold1", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'hA2A2_0000_0000_0002));
    cyc();
    chk("stall_w2_hold2", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'hA2A2_0000_0000_0002));
    ready_in = 1'b1;
    cyc();
    chk("stall_w3", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'hA3A3_0000_0000_0003));
    cyc();
    chk("stall_w4", out_w, ow(1'b1, 1'b0, 1'b1, 3'd0, 64'hA4A4_0000_0000_0004));
    cyc();
    chk("stall_gap", 72'(valid_out), 72'(0));
    repeat (3) cyc();

    // Two single-word packets back to back: one idle cycle between them
    wr(1'b1, 1'b1, 3'd3, 64'h5555_0000_0000_0005);
    wr(1'b1, 1'b1, 3'd0, 64'h6666_0000_0000_0006);
    chk("ipg_pre", 72'(valid_out), 72'(0));
    cyc();
    chk("ipg_p1", out_w, ow(1'b1, 1'b1, 1'b1, 3'd3, 64'h5555_0000_0000_0005));
    cyc();
    chk("ipg_gap", 72'(valid_out), 72'(0));
    cyc();
    chk("ipg_p2", out_w, ow(1'b1, 1'b1, 1'b1, 3'd0, 64'h6666_0000_0000_0006));
    cyc();
    chk("ipg_after", 72'(valid_out), 72'(0));
    chk("ipg_drop", 72'(drop_count), 72'(0));
    repeat (3) cyc();

    // sop, word, sop, eop: first packet aborted
    wr(1'b1, 1'b0, 3'd0, 64'hDEAD_0000_0000_0001);
    wr(1'b0, 1'b0, 3'd0, 64'hDEAD_0000_0000_0002);
    wr(1'b1, 1'b0, 3'd0, 64'hB0B0_0000_0000_0001);
    wr(1'b0, 1'b1, 3'd7, 64'hB0B0_0000_0000_0002);
    chk("abort_drop", 72'(drop_count), 72'(1));
    cyc();
    cyc();
    chk("abort_b1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'hB0B0_0000_0000_0001));
    cyc();
    chk("abort_b2", out_w, ow(1'b1, 1'b0, 1'b1, 3'd7, 64'hB0B0_0000_0000_0002));
    cyc();
    chk("abort_gap", 72'(valid_out), 72'(0));
    repeat (3) cyc();

    // Run of two stray words: counted once, never sent
    wr(1'b0, 1'b0, 3'd0, 64'hBAD0_0000_0000_0001);
    wr(1'b0, 1'b0, 3'd0, 64'hBAD0_0000_0000_0002);
    chk("stray_drop", 72'(drop_count), 72'(2));
    cyc();
    cyc();
    chk("stray_no_tx", 72'(valid_out), 72'(0));

    // Clean reset between cases
    rst_n = 1'b0;
    #1;
    chk("midreset_drop_clear", 72'(drop_count), 72'(0));
    cyc();
    rst_n = 1'b1;
    cyc();

    // 20-word packet into a 16-deep buffer: oversize drop
    for (int i = 1; i <= 20; i++) begin
      if (wr_ready !== 1'b1) nr = 1'b1;
      if (valid_out !== 1'b0) sv = 1'b1;
      wr(i == 1, i == 20, 3'd0, 64'(i));
    end
    repeat (3) begin
      if (valid_out !== 1'b0) sv = 1'b1;
      cyc();
    end
    chk("oversize_wr_ready", 72'(nr), 72'(0));
    chk("oversize_no_tx", 72'(sv), 72'(0));
    chk("oversize_drop", 72'(drop_count), 72'(1));
    wr(1'b1, 1'b0, 3'd0, 64'hC1C1_0000_0000_0001);
    wr(1'b0, 1'b1, 3'd2, 64'hC2C2_0000_0000_0002);
    cyc();
    cyc();
    chk("oversize_next_w1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'hC1C1_0000_0000_0001));
    cyc();
    chk("oversize_next_w2", out_w, ow(1'b1, 1'b0, 1'b1, 3'd2, 64'hC2C2_0000_0000_0002));
    repeat (4) cyc();

    // Reset during word 2 of a 4-word packet
    wr(1'b1, 1'b0, 3'd0, 64'hE1E1_0000_0000_0001);
    wr(1'b0, 1'b0, 3'd0, 64'hE2E2_0000_0000_0002);
    wr(1'b0, 1'b0, 3'd0, 64'hE3E3_0000_0000_0003);
    wr(1'b0, 1'b1, 3'd1, 64'hE4E4_0000_0000_0004);
    cyc();
    cyc();
    chk("rst_pkt_w1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'hE1E1_0000_0000_0001));
    cyc();
    chk("rst_pkt_w2", out_w, ow(1'b1, 1'b0, 1'b0, 3'd0, 64'hE2E2_0000_0000_0002));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out", out_w, 72'd0);
    chk("rst_async_wr_ready", 72'(wr_ready), 72'(0));
    chk("rst_async_drop", 72'(drop_count), 72'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_release_wr_ready", 72'(wr_ready), 72'(1));
    sv = 1'b0;
    repeat (4) begin
      if (valid_out !== 1'b0) sv = 1'b1;
      cyc();
    end
    chk("rst_no_leftover", 72'(sv), 72'(0));
    wr(1'b1, 1'b0, 3'd0, 64'hF1F1_0000_0000_0001);
    wr(1'b0, 1'b1, 3'd4, 64'hF2F2_0000_0000_0002);
    cyc();
    cyc();
    chk("post_rst_w1", out_w, ow(1'b1, 1'b1, 1'b0, 3'd0, 64'hF1F1_0000_0000_0001));
    cyc();
    chk("post_rst_w2", out_w, ow(1'b1, 1'b0, 1'b1, 3'd4, 64'hF2F2_0000_0000_0002));
    chk("post_rst_drop", 72'(drop_count), 72'(0));
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
